// File: rtl/mult_seq_param_pkg.sv
// mult_seq_param_pkg: shared types and helpers for the sequential multiplier.
// Rev 1.0
`default_nettype none

package mult_seq_param_pkg;

  // Widest vector the parity helper accepts; callers zero-extend to this width.
  localparam int MAX_PARITY_W = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  typedef enum logic [1:0] {
    UNSIGNED_A_B = 2'd0,
    SIGNED_A_B   = 2'd1
  } operation_t;

  function automatic logic parity(input logic [MAX_PARITY_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_seq_param_core.sv
// mult_shift_add_core: radix-2 shift-add engine, one multiplier bit per step.
// Rev 1.0
`default_nettype none

module mult_shift_add_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      cnt;

  // The load retires bit 0 so the remaining WIDTH-1 bits take WIDTH-1 steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      ma  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mb  <= b >> 1;
      cnt <= CW'(1);
    end else if (step) begin
      if (mb[0]) begin
        acc <= acc + ma;
      end
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/mult_seq_param.sv
// mult_seq_param: parity-checked sequential multiplier with req/ack handshake.
// Rev 1.0
`default_nettype none

module mult_seq_param
  import mult_seq_param_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  input  logic               is_signed,
  output logic               ack,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               arg_parity_error,
  output logic               result_rdy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         state;
  logic               neg;
  logic               perr;
  logic               a_ok;
  logic               b_ok;
  logic               start;
  logic               step;
  logic               last;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;

  assign a_ok = (arg_a_parity == parity((MAX_PARITY_W)'(arg_a), ODD_PARITY));
  assign b_ok = (arg_b_parity == parity((MAX_PARITY_W)'(arg_b), ODD_PARITY));

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct as unsigned.
  assign mag_a = (is_signed && arg_a[WIDTH-1]) ? -arg_a : arg_a;
  assign mag_b = (is_signed && arg_b[WIDTH-1]) ? -arg_b : arg_b;

  assign start   = (state == S_IDLE) && req;
  assign step    = (state == S_CALC);
  assign product = perr ? '0 : (neg ? -acc : acc);

  mult_shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .a     (mag_a),
    .b     (mag_b),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      neg              <= 1'b0;
      perr             <= 1'b0;
      ack              <= 1'b0;
      busy             <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      result_rdy       <= 1'b0;
    end else begin
      ack        <= 1'b0;
      result_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            ack   <= 1'b1;
            busy  <= 1'b1;
            neg   <= is_signed & (arg_a[WIDTH-1] ^ arg_b[WIDTH-1]);
            perr  <= ~(a_ok & b_ok);
            state <= (a_ok & b_ok) ? S_CALC : S_DONE;
          end
        end
        S_CALC: begin
          if (last) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          result           <= product;
          result_parity    <= parity((MAX_PARITY_W)'(product), ODD_PARITY);
          arg_parity_error <= perr;
          result_rdy       <= 1'b1;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
